// File: rtl/elastic_stage_register.sv
// Generic stallable/flushable pipeline stage with valid/ready handshake,
// optional 2-entry skid buffer, NOP insertion on flush and a bubble counter.
module elastic_stage_register #(
    parameter int unsigned       CTRL_W   = 16,
    parameter int unsigned       DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter logic [DATA_W-1:0] DATA_NOP = {DATA_W/8{8'h2A}},
    parameter int unsigned       SKID     = 1,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Flush,
    input  logic              Valid_In,
    output logic              Ready_Out,
    input  logic [CTRL_W-1:0] Ctrl_In,
    input  logic [DATA_W-1:0] Data_In,
    output logic              Valid_Out,
    input  logic              Ready_In,
    output logic [CTRL_W-1:0] Ctrl_Out,
    output logic [DATA_W-1:0] Data_Out,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  Bubble_Cnt
);

    localparam int unsigned OCC_W = 2;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_e;
    logic [CNT_W-1:0] bub_q;
    logic             accept;
    logic             take;

    assign in_e      = '{ctrl: Ctrl_In, data: Data_In};
    assign Valid_Out = (state_q != S_EMPTY);
    assign take      = Valid_Out & Ready_In;
    assign accept    = Valid_In & Ready_Out;

    // Skid build decouples Ready_Out from Ready_In; single-entry build passes it through.
    generate
        if (SKID != 0) begin : g_skid
            assign Ready_Out = RST_N & (state_q != S_FULL);
        end else begin : g_noskid
            assign Ready_Out = RST_N & (~Valid_Out | Ready_In);
        end
    endgenerate

    // Next-state and entry movement; flush overrides any handshake this cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_ONE;
                    main_d  = in_e;
                end
            end
            S_ONE: begin
                if (accept && take) begin
                    main_d = in_e;
                end else if (accept && (SKID != 0)) begin
                    state_d = S_FULL;
                    skid_d  = in_e;
                end else if (take) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (take) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (Flush) begin
            state_d = S_EMPTY;
            main_d  = '{ctrl: CTRL_NOP, data: DATA_NOP};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_EMPTY;
            main_q  <= '{ctrl: CTRL_NOP, data: '0};
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Saturating count of edges that see no valid head entry.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bub_q <= '0;
        end else if (!Valid_Out && (bub_q != {CNT_W{1'b1}})) begin
            bub_q <= bub_q + CNT_W'(1);
        end
    end

    always_comb begin
        Occupancy = OCC_W'(0);
        case (state_q)
            S_ONE:   Occupancy = OCC_W'(1);
            S_FULL:  Occupancy = OCC_W'(2);
            default: Occupancy = OCC_W'(0);
        endcase
    end

    assign Ctrl_Out   = Valid_Out ? main_q.ctrl : CTRL_NOP;
    assign Data_Out   = main_q.data;
    assign Bubble_Cnt = bub_q;

endmodule

// File: tb/tb_elastic_stage_register.sv
// Bench for elastic_stage_register: skid build (CNT_W=4) and single-entry build,
// checked each cycle against a FIFO-level model plus hand-computed points.
module tb_elastic_stage_register;

    localparam logic [127:0] NOP_D = {16{8'h2A}};

    typedef struct packed {
        logic [15:0]  c;
        logic [127:0] d;
    } ent_t;

    logic         CLK;
    logic         rst_n  [2];
    logic         flush  [2];
    logic         vin    [2];
    logic         rout   [2];
    logic [15:0]  cin    [2];
    logic [127:0] din    [2];
    logic         vout   [2];
    logic         rin    [2];
    logic [15:0]  cout   [2];
    logic [127:0] dout   [2];
    logic [1:0]   occ    [2];
    logic [3:0]   bub_a;
    logic [15:0]  bub_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: small FIFO per DUT, last-shown data, bubble count.
    ent_t         m_buf  [2][2];
    int           m_cnt  [2];
    logic [127:0] m_dout [2];
    int           m_bub  [2];
    bit           m_live [2];

    elastic_stage_register #(.CTRL_W(16), .DATA_W(128), .SKID(1), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(rst_n[0]), .Flush(flush[0]), .Valid_In(vin[0]),
        .Ready_Out(rout[0]), .Ctrl_In(cin[0]), .Data_In(din[0]), .Valid_Out(vout[0]),
        .Ready_In(rin[0]), .Ctrl_Out(cout[0]), .Data_Out(dout[0]), .Occupancy(occ[0]),
        .Bubble_Cnt(bub_a)
    );

    elastic_stage_register #(.CTRL_W(16), .DATA_W(128), .SKID(0), .CNT_W(16)) dut_ns (
        .CLK(CLK), .RST_N(rst_n[1]), .Flush(flush[1]), .Valid_In(vin[1]),
        .Ready_Out(rout[1]), .Ctrl_In(cin[1]), .Data_In(din[1]), .Valid_Out(vout[1]),
        .Ready_In(rin[1]), .Ctrl_Out(cout[1]), .Data_Out(dout[1]), .Occupancy(occ[1]),
        .Bubble_Cnt(bub_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    // Model update on each rising edge, from the rules of the handshake.
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            logic mv, mr;
            int   bmax;
            bmax = (k == 0) ? 15 : 65535;
            if (!rst_n[k]) begin
                m_cnt[k]  = 0;
                m_dout[k] = '0;
                m_bub[k]  = 0;
                m_live[k] = 1'b1;
            end else begin
                mv = (m_cnt[k] != 0);
                mr = (k == 0) ? (m_cnt[k] < 2) : (!mv || rin[k]);
                if (!mv && m_bub[k] < bmax) m_bub[k]++;
                if (flush[k]) begin
                    m_cnt[k]  = 0;
                    m_dout[k] = NOP_D;
                end else begin
                    if (mv && rin[k]) begin
                        m_buf[k][0] = m_buf[k][1];
                        m_cnt[k]--;
                    end
                    if (vin[k] && mr && m_cnt[k] < 2) begin
                        m_buf[k][m_cnt[k]] = '{c: cin[k], d: din[k]};
                        m_cnt[k]++;
                    end
                    if (m_cnt[k] != 0) m_dout[k] = m_buf[k][0].d;
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (m_live[k]) begin
                logic        ev, er;
                logic [15:0] ab;
                ev = (m_cnt[k] != 0);
                er = (k == 0) ? (rst_n[k] && m_cnt[k] < 2) : (rst_n[k] && (!ev || rin[k]));
                ab = (k == 0) ? 16'(bub_a) : bub_b;
                chk($sformatf("m%0d_valid", k), 128'(vout[k]), 128'(ev));
                chk($sformatf("m%0d_ready", k), 128'(rout[k]), 128'(er));
                chk($sformatf("m%0d_occ", k), 128'(occ[k]), 128'(m_cnt[k]));
                chk($sformatf("m%0d_ctrl", k), 128'(cout[k]), ev ? 128'(m_buf[k][0].c) : 128'(0));
                chk($sformatf("m%0d_data", k), dout[k], m_dout[k]);
                chk($sformatf("m%0d_bub", k), 128'(ab), 128'(m_bub[k]));
            end
        end
    end

    initial begin
        int   cur;
        logic pat [7];
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; flush[k] = 1'b0; vin[k] = 1'b0; rin[k] = 1'b0;
            cin[k] = '0; din[k] = '0;
        end
        tick();
        tick();
        chk("rst_valid", 128'(vout[0]), 128'(0));
        chk("rst_occ", 128'(occ[0]), 128'(0));
        chk("rst_data", dout[0], 128'(0));
        chk("rst_ready", 128'(rout[0]), 128'(0));
        chk("rst_bub", 128'(bub_a), 128'(0));

        rst_n[0] = 1'b1;
        #1;
        chk("rel_ready", 128'(rout[0]), 128'(1));

        // Idle for 20 cycles: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) tick();
        chk("bub_sat", 128'(bub_a), 128'(15));

        // Stream 1,2,3 with Ready_In=1
        rin[0] = 1'b1;
        vin[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din[0] = 128'(i);
            cin[0] = 16'hC000 | 16'(i);
            tick();
            chk("str_data", dout[0], 128'(i));
            chk("str_ctrl", 128'(cout[0]), 128'(16'hC000 | 16'(i)));
            chk("str_occ", 128'(occ[0]), 128'(1));
            chk("str_ready", 128'(rout[0]), 128'(1));
        end
        vin[0] = 1'b0;
        tick();
        chk("drain_valid", 128'(vout[0]), 128'(0));
        chk("drain_hold", dout[0], 128'(3));
        chk("drain_ctrl", 128'(cout[0]), 128'(0));
        chk("bub_stay", 128'(bub_a), 128'(15));

        // Backpressure into the skid register
        rin[0] = 1'b0;
        vin[0] = 1'b1; din[0] = 128'(5); cin[0] = 16'h0005;
        tick();
        chk("bp_data5", dout[0], 128'(5));
        din[0] = 128'(6); cin[0] = 16'h0006;
        tick();
        chk("bp_occ2", 128'(occ[0]), 128'(2));
        chk("bp_ready0", 128'(rout[0]), 128'(0));
        chk("bp_head5", dout[0], 128'(5));
        vin[0] = 1'b0; rin[0] = 1'b1;
        tick();
        chk("bp_data6", dout[0], 128'(6));
        chk("bp_ready1", 128'(rout[0]), 128'(1));
        chk("bp_occ1", 128'(occ[0]), 128'(1));
        tick();
        chk("bp_empty", 128'(occ[0]), 128'(0));

        // Flush while FULL with 7 offered
        rin[0] = 1'b0;
        vin[0] = 1'b1; din[0] = 128'(8); cin[0] = 16'h0008;
        tick();
        din[0] = 128'(9); cin[0] = 16'h0009;
        tick();
        din[0] = 128'(7); cin[0] = 16'hFFFF;
        flush[0] = 1'b1;
        tick();
        chk("fl_valid", 128'(vout[0]), 128'(0));
        chk("fl_occ", 128'(occ[0]), 128'(0));
        chk("fl_ctrl", 128'(cout[0]), 128'(0));
        chk("fl_data", dout[0], NOP_D);
        chk("fl_ready", 128'(rout[0]), 128'(1));
        tick();
        chk("fl2_occ", 128'(occ[0]), 128'(0));
        flush[0] = 1'b0; vin[0] = 1'b0; rin[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no7", 128'(vout[0]), 128'(0));
        end

        // Reset while FULL
        rin[0] = 1'b0;
        vin[0] = 1'b1; din[0] = 128'(16); cin[0] = 16'h0010;
        tick();
        din[0] = 128'(17); cin[0] = 16'h0011;
        tick();
        chk("mr_occ2", 128'(occ[0]), 128'(2));
        rst_n[0] = 1'b0;
        tick();
        chk("mr_valid", 128'(vout[0]), 128'(0));
        chk("mr_data", dout[0], 128'(0));
        chk("mr_bub", 128'(bub_a), 128'(0));
        chk("mr_ready", 128'(rout[0]), 128'(0));
        tick();
        chk("mr_ready2", 128'(rout[0]), 128'(0));
        vin[0] = 1'b0;
        rst_n[0] = 1'b1;
        #1;
        chk("mr_rel", 128'(rout[0]), 128'(1));
        tick();

        // Single-entry build: Ready_Out tracks Ready_In with continuous Valid_In
        rst_n[1] = 1'b1;
        vin[1] = 1'b1; rin[1] = 1'b0;
        din[1] = 128'(256); cin[1] = 16'h0100;
        tick();
        chk("ns_first", dout[1], 128'(256));
        cur = 257;
        din[1] = 128'(cur); cin[1] = 16'(cur);
        for (int i = 0; i < 7; i++) begin
            rin[1] = pat[i];
            #1;
            chk("ns_ready", 128'(rout[1]), 128'(pat[i]));
            tick();
            if (pat[i]) begin
                cur++;
                din[1] = 128'(cur); cin[1] = 16'(cur);
            end
        end
        chk("ns_count", dout[1], 128'(260));
        chk("ns_occ", 128'(occ[1]), 128'(1));
        vin[1] = 1'b0; rin[1] = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elastic_stage_register.md
Name: elastic_stage_register

Overview:
- Parametrised pipeline stage register for the RV32i pipeline: one generic, stallable, flushable register with a valid/ready handshake. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque control bundle and an opaque data bundle per entry.
- An optional 2-entry skid buffer cuts the ready path between stages.
- Flush inserts a configurable NOP; a saturating counter reports bubble cycles for performance analysis.

Parameters:
- CTRL_W, 16, width of control bundle (write enables, mux selects, ALU op).
- DATA_W, 128, width of data bundle (register data, immediate, PC, PC+4).
- CTRL_NOP, 0 (CTRL_W bits), control value presented whenever no valid entry is output.
- DATA_NOP, {DATA_W/8{8'h2A}}, data value loaded on flush (debug pattern).
- SKID, 1, 1 = 2-entry skid buffer with registered Ready_Out; 0 = single entry with combinational Ready_Out.
- CNT_W, 16, width of bubble counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- Flush  in  1  synchronous kill of all held entries.
- Valid_In  in  1  upstream entry valid.
- Ready_Out  out  1  stage can accept an upstream entry.
- Ctrl_In  in  CTRL_W  upstream control bundle.
- Data_In  in  DATA_W  upstream data bundle.
- Valid_Out  out  1  head entry valid.
- Ready_In  in  1  downstream accepts the head entry.
- Ctrl_Out  out  CTRL_W  head control bundle; CTRL_NOP when Valid_Out=0.
- Data_Out  out  DATA_W  head data bundle.
- Occupancy  out  2  entries held (0..2; never exceeds 1 when SKID=0).
- Bubble_Cnt  out  CNT_W  saturating count of cycles with Valid_Out=0.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On an edge with RST_N=0:
  - all entries are invalidated;
  - Valid_Out=0, Occupancy=0, Data_Out=0, Ctrl_Out=CTRL_NOP, Bubble_Cnt=0.
  - Ready_Out=0 while RST_N=0 (gated with RST_N) and rises with no extra cycle after release.
  - Reset mid-transfer discards all entries; the handshake in that cycle is ignored.
- Handshakes:
  - Accept = Valid_In & Ready_Out; Take = Valid_Out & Ready_In.
  - The source must hold Valid_In and the payload stable until accepted.
  - Once Valid_Out=1, the block holds Valid_Out and the payload stable until taken.
- Latency: 1 cycle from accept to Valid_Out when empty. Throughput is 1 entry/cycle. Order is preserved.
- SKID=1 state machine (main register + skid register):
  - EMPTY: Accept -> ONE (main <= input).
  - ONE:
    - Accept & Take -> ONE (main <= input).
    - Accept & !Take -> FULL (skid <= input).
    - !Accept & Take -> EMPTY.
    - otherwise hold.
  - FULL: Take -> ONE (main <= skid). Accept cannot occur in FULL.
  - Ready_Out is registered: 1 in EMPTY/ONE, 0 in FULL, so it has no combinational path from Ready_In.
- SKID=0:
  - Ready_Out = RST_N & (!Valid_Out | Ready_In), combinational.
  - Accept loads the register; Take without Accept empties it.
- Flush:
  - Priority: reset > flush > normal operation.
  - On an edge with Flush=1: all entries invalidated, Occupancy=0, Data_Out <= DATA_NOP, Ctrl_Out=CTRL_NOP.
  - Any Accept or Take in the flush cycle is discarded. The entry offered that cycle is not captured, and the upstream must treat it as killed.
  - Ready_Out=1 (SKID=1) in the following cycle.
  - Flush held for multiple cycles keeps the stage empty.
- Ctrl_Out masking: Ctrl_Out = Valid_Out ? head.ctrl : CTRL_NOP (combinational mux). A bubble can therefore never assert a state-changing control bit.
- Data_Out when empty after normal drain: holds the last taken entry's data (no toggle).
- Bubble_Cnt:
  - Increments on every edge where RST_N=1 and Valid_Out=0, including flush cycles.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.

Test Plan:
- Reset then stream: Ready_In=1, send Data_In=1,2,3 on consecutive cycles -> Data_Out=1,2,3 on cycles +1..+3; Occupancy stays 1; Ready_Out stays 1.
- Backpressure (SKID=1):
  - Setup: one entry held (Data_Out=5), Ready_In=0, send Data_In=6.
  - Expected: Occupancy=2, Ready_Out=0.
  - Then raise Ready_In: Data_Out=5 then 6; Ready_Out=1 one cycle after the first take; no loss or duplication.
- Flush while FULL with Valid_In=1 (Data_In=7):
  - Next cycle Valid_Out=0, Occupancy=0, Ctrl_Out=CTRL_NOP, Data_Out=0x2A2A…2A.
  - 7 never appears on the output.
- Reset mid-stream: RST_N=0 while Occupancy=2 -> next cycle Valid_Out=0, Data_Out=0, Bubble_Cnt=0, Ready_Out=0 until RST_N=1.
- SKID=0 build: Valid_Out=1, Ready_In toggling 0/1 with continuous Valid_In -> Ready_Out follows Ready_In combinationally in the same cycle; one entry is transferred per cycle where Ready_In=1.
- Bubble counter (CNT_W=4): hold Valid_In=0 for 20 cycles after reset -> Bubble_Cnt reaches 15 and stays 15; a valid entry at Data_Out leaves it unchanged.
